// File: rtl/rx_shift_buffer.sv
// rtl/rx_shift_buffer.sv - LSB-first serial-to-parallel receive shifter with holding register.
// Optional even-parity frame bit enabled by defining RX_PARITY_CHECK_EN.
module rx_shift_buffer #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             data_in,
    input  logic             clear,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [CW-1:0]    bit_count,
    output logic             overrun,
    output logic             parity_err
);

`ifdef RX_PARITY_CHECK_EN
    localparam int SW = WIDTH;
`else
    // The final data bit goes straight from data_in into rx_data, so only
    // WIDTH-1 bits ever need to be stored.
    localparam int SW = WIDTH - 1;
`endif

    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PARITY
    } state_t;

    state_t            state, state_next;
    logic [SW-1:0]     sreg, sreg_next;
    logic [WIDTH-1:0]  word;
    logic              complete;
    logic              holding_free;

    assign holding_free = !rx_valid || rd_en;

    always_comb begin
        state_next = state;
        complete   = 1'b0;
`ifdef RX_PARITY_CHECK_EN
        sreg_next  = {data_in, sreg[WIDTH-1:1]};
        word       = sreg;
`else
        word       = {data_in, sreg};
        sreg_next  = word[WIDTH-1:1];
`endif
        case (state)
            IDLE: begin
                if (shift) state_next = RECV;
            end
            RECV: begin
                if (shift && bit_count == LAST_DATA) begin
`ifdef RX_PARITY_CHECK_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
                    complete   = 1'b1;
`endif
                end
            end
            PARITY: begin
                if (shift) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            complete   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            bit_count <= '0;
            overrun   <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (clear) begin
                sreg      <= '0;
                bit_count <= '0;
                overrun   <= 1'b0;
                rx_valid  <= 1'b0;
            end else begin
                if (shift) begin
                    bit_count <= complete ? '0 : bit_count + 1'b1;
                    // The parity strobe is consumed without disturbing the stored word.
                    if (state != PARITY) sreg <= sreg_next;
                end
                if (complete) begin
                    if (holding_free) begin
                        rx_data  <= word;
                        rx_valid <= 1'b1;
`ifdef RX_PARITY_CHECK_EN
                        parity_err <= ^sreg ^ data_in;
`endif
                    end else begin
                        overrun <= 1'b1;
                    end
                end else if (rd_en && rx_valid) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

`ifndef RX_PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_shift_buffer.sv
// tb/tb_rx_shift_buffer.sv - self-checking bench for rx_shift_buffer (vector table, directed and random).
module tb_rx_shift_buffer;
    localparam int W = 32;
    localparam int CW = $clog2(W + 1);
`ifdef RX_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = W + (PAR ? 1 : 0);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          shift = 1'b0;
    logic          data_in = 1'b0;
    logic          clear = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic [CW-1:0] bit_count;
    logic          overrun;
    logic          parity_err;

    rx_shift_buffer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .shift(shift), .data_in(data_in), .clear(clear),
        .rd_en(rd_en), .rx_data(rx_data), .rx_valid(rx_valid), .bit_count(bit_count),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: a queue of received frame bits plus the holding flags.
    bit           mq[$];
    logic [W-1:0] m_data;
    logic         m_valid, m_ovr, m_perr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic d, input logic c, input logic r);
        logic [W-1:0] w;
        logic p;
        logic done;
        done = 1'b0; w = '0; p = 1'b0;
        if (c) begin
            mq.delete();
            m_ovr = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (s) begin
                mq.push_back(d);
                if (mq.size() == FL) begin
                    done = 1'b1;
                    foreach (mq[i]) begin
                        if (i < W) w[i] = mq[i];
                        p = p ^ mq[i];
                    end
                    mq.delete();
                end
            end
            if (done) begin
                if (!m_valid || r) begin
                    m_data = w;
                    m_valid = 1'b1;
                    if (PAR) m_perr = p;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (r) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic s, input logic d, input logic c, input logic r);
        @(negedge clk);
        shift = s; data_in = d; clear = c; rd_en = r;
        @(posedge clk);
        model_step(s, d, c, r);
        #1;
        chk("step_data", 64'(rx_data), 64'(m_data));
        chk("step_valid", 64'(rx_valid), 64'(m_valid));
        chk("step_count", 64'(bit_count), 64'(mq.size()));
        chk("step_overrun", 64'(overrun), 64'(m_ovr));
        chk("step_parity", 64'(parity_err), 64'(m_perr));
        shift = 1'b0; data_in = 1'b0; clear = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rd_last, input logic flip_par);
        for (int i = 0; i < W; i++)
            step(1'b1, w[i], 1'b0, (i == W - 1 && !PAR) ? rd_last : 1'b0);
        if (PAR) step(1'b1, (^w) ^ flip_par, 1'b0, rd_last);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic         clr_before;
        logic         rd_last;
        logic [W-1:0] exp_data;
        logic         exp_valid;
        logic         exp_ovr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{32'hA5A5_0F01, 1'b0, 1'b0, 32'hA5A5_0F01, 1'b1, 1'b0};
        tbl[1] = '{32'h1234_5678, 1'b0, 1'b0, 32'hA5A5_0F01, 1'b1, 1'b1};
        tbl[2] = '{32'hCAFE_BABE, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b1};
        tbl[3] = '{32'h0000_FFFF, 1'b0, 1'b1, 32'h0000_FFFF, 1'b1, 1'b1};
        tbl[4] = '{32'hFFFF_0000, 1'b1, 1'b0, 32'hFFFF_0000, 1'b1, 1'b0};

        do_reset();
        #1;
        chk("reset_data", 64'(rx_data), 64'h0);
        chk("reset_valid", 64'(rx_valid), 64'h0);
        chk("reset_count", 64'(bit_count), 64'h0);
        chk("reset_overrun", 64'(overrun), 64'h0);
        chk("reset_parity", 64'(parity_err), 64'h0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].clr_before) begin
                step(1'b0, 1'b0, 1'b1, 1'b0);
                chk("clear_valid", 64'(rx_valid), 64'h0);
                chk("clear_overrun", 64'(overrun), 64'h0);
                chk("clear_keeps_data", 64'(rx_data), 64'(tbl[i - 1].exp_data));
            end
            send_word(tbl[i].word, tbl[i].rd_last, 1'b0);
            chk("tbl_data", 64'(rx_data), 64'(tbl[i].exp_data));
            chk("tbl_valid", 64'(rx_valid), 64'(tbl[i].exp_valid));
            chk("tbl_overrun", 64'(overrun), 64'(tbl[i].exp_ovr));
            chk("tbl_count", 64'(bit_count), 64'h0);
        end

        // Read and refill on the same edge: no loss, no overrun.
        send_word(32'h0F0F_1234, 1'b1, 1'b0);
        chk("rd_refill_data", 64'(rx_data), 64'h0F0F_1234);
        chk("rd_refill_valid", 64'(rx_valid), 64'h1);
        chk("rd_refill_overrun", 64'(overrun), 64'h0);

        // Read without transfer drops valid but keeps data; a second read is a no-op.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("read_valid", 64'(rx_valid), 64'h0);
        chk("read_data", 64'(rx_data), 64'h0F0F_1234);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Partial frame flushed by clear leaves no stale bits behind.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("partial_count", 64'(bit_count), 64'd16);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("partial_holds", 64'(bit_count), 64'd16);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 64'(bit_count), 64'h0);
        for (int i = 0; i < W; i++) begin
            step(1'b1, (i < 16) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            chk("frame_count", 64'(bit_count), (i == FL - 1) ? 64'h0 : 64'(i + 1));
        end
        if (PAR) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_data", 64'(rx_data), 64'h0000_FFFF);
        chk("flush_valid", 64'(rx_valid), 64'h1);

        // Asynchronous reset mid-frame.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'(i), 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", 64'(rx_data), 64'h0);
        chk("async_rst_valid", 64'(rx_valid), 64'h0);
        chk("async_rst_count", 64'(bit_count), 64'h0);
        chk("async_rst_overrun", 64'(overrun), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("post_rst_data", 64'(rx_data), 64'hDEAD_BEEF);
        chk("post_rst_valid", 64'(rx_valid), 64'h1);

`ifdef RX_PARITY_CHECK_EN
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) step(1'b1, (i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        chk("par_wait_valid", 64'(rx_valid), 64'h0);
        chk("par_wait_count", 64'(bit_count), 64'(W));
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_ok_valid", 64'(rx_valid), 64'h1);
        chk("par_ok_err", 64'(parity_err), 64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(32'h0000_0001, 1'b0, 1'b1);
        chk("par_bad_data", 64'(rx_data), 64'h1);
        chk("par_bad_err", 64'(parity_err), 64'h1);
`endif

        // Randomised traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
